// File: rtl/ltc1865_ch_scheduler_if.sv
// Handshake bundle between the channel scheduler and the LTC1865 ADC controller.
// master: scheduler side (drives enable/start/channel, receives frame data).
// slave:  ADC controller side.
interface ltc1865_ch_scheduler_if;
  logic        o_ctrl_en;
  logic        o_ctrl_txe_n;
  logic        o_ctrl_ch;
  logic        i_ctrl_rx_dv;
  logic [15:0] i_ctrl_data;

  modport master (
    output o_ctrl_en,
    output o_ctrl_txe_n,
    output o_ctrl_ch,
    input  i_ctrl_rx_dv,
    input  i_ctrl_data
  );

  modport slave (
    input  o_ctrl_en,
    input  o_ctrl_txe_n,
    input  o_ctrl_ch,
    output i_ctrl_rx_dv,
    output i_ctrl_data
  );
endinterface

// File: rtl/ltc1865_ch_scheduler.sv
// LTC1865 channel scheduler: round-robins conversions over the enabled
// channels, enforces the inter-frame gap and a WAIT_DV timeout, and routes
// each returned word to the channel selected one frame earlier (the ADC
// returns the previous conversion). The first frame after IDLE is priming.
// Optional feature: define LTC1865_SCHED_AVG_EN to output the mean of every
// 4 accepted samples per channel instead of each sample.
module ltc1865_ch_scheduler #(
  parameter int unsigned GAP_CLK     = 8200,
  parameter int unsigned TIMEOUT_CLK = 16384
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_run,
  input  logic [1:0]                   i_ch_mask,
  ltc1865_ch_scheduler_if.master       ctrl,
  output logic [15:0]                  o_ch0_data,
  output logic [15:0]                  o_ch1_data,
  output logic                         o_ch0_dv,
  output logic                         o_ch1_dv,
  output logic                         o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DV,
    S_GAP
  } state_t;

  localparam logic [31:0] GAP_LAST = (GAP_CLK > 0)     ? 32'(GAP_CLK - 1)     : '0;
  localparam logic [31:0] TO_LAST  = (TIMEOUT_CLK > 0) ? 32'(TIMEOUT_CLK - 1) : '0;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ch_q;
  logic        first_q;
  logic        prev_ch_q;
  logic        prev_valid_q;
  logic        run_q;
  logic        timeout_q;
  logic [15:0] ch0_data_q, ch1_data_q;
  logic        ch0_dv_q, ch1_dv_q;

  logic        sel_ch;
  logic        rx_fire;
  logic        accept;
  logic        timeout_fire;
  logic        go;

  assign go           = i_run && (i_ch_mask != 2'b00);
  assign rx_fire      = (state_q == S_WAIT_DV) && ctrl.i_ctrl_rx_dv;
  assign accept       = rx_fire && prev_valid_q;
  assign timeout_fire = (state_q == S_WAIT_DV) && !ctrl.i_ctrl_rx_dv && (cnt_q >= TO_LAST);

  // Channel choice for the current START: ch0 first after IDLE, then alternate
  // over enabled bits; an empty mask keeps the last channel.
  always_comb begin
    sel_ch = ch_q;
    unique case (i_ch_mask)
      2'b01:   sel_ch = 1'b0;
      2'b10:   sel_ch = 1'b1;
      2'b11:   sel_ch = first_q ? 1'b0 : ~ch_q;
      default: sel_ch = ch_q;
    endcase
  end

  // State and shared cycle counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and saturating counter logic (counter restarts on each phase entry).
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT_DV;
      end
      S_WAIT_DV: begin
        if (ctrl.i_ctrl_rx_dv) begin
          state_d = S_GAP;
        end else if (cnt_q >= TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = go ? S_START : S_IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller-facing outputs; the channel is shown combinationally in START
  // and held in ch_q through WAIT_DV.
  always_comb begin
    ctrl.o_ctrl_en    = (state_q != S_IDLE);
    ctrl.o_ctrl_txe_n = (state_q != S_START);
    ctrl.o_ctrl_ch    = (state_q == S_START) ? sel_ch : ch_q;
  end

  // Channel selection and previous-frame tracking for the pipelined ADC.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ch_q         <= 1'b0;
      first_q      <= 1'b1;
      prev_ch_q    <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      if (state_q == S_START) begin
        ch_q    <= sel_ch;
        first_q <= 1'b0;
      end
      if (state_d == S_IDLE) begin
        first_q      <= 1'b1;
        prev_valid_q <= 1'b0;
      end else if (rx_fire) begin
        prev_ch_q    <= ch_q;
        prev_valid_q <= 1'b1;
      end
    end
  end

  // Sticky timeout flag, cleared on a rising edge of i_run.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      run_q <= i_run;
      if (timeout_fire) begin
        timeout_q <= 1'b1;
      end else if (i_run && !run_q) begin
        timeout_q <= 1'b0;
      end
    end
  end

`ifdef LTC1865_SCHED_AVG_EN
  logic [17:0] acc_q [2];
  logic [1:0]  n_q   [2];
  logic [17:0] sum;

  assign sum = acc_q[prev_ch_q] + {2'b00, ctrl.i_ctrl_data};

  // Per-channel 4-sample accumulator; emits sum>>2 with one dv per 4 samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        acc_q[i] <= '0;
        n_q[i]   <= '0;
      end
      ch0_data_q <= '0;
      ch1_data_q <= '0;
      ch0_dv_q   <= 1'b0;
      ch1_dv_q   <= 1'b0;
    end else begin
      ch0_dv_q <= 1'b0;
      ch1_dv_q <= 1'b0;
      if (state_q == S_IDLE) begin
        for (int unsigned i = 0; i < 2; i++) begin
          acc_q[i] <= '0;
          n_q[i]   <= '0;
        end
      end else if (accept) begin
        if (n_q[prev_ch_q] == 2'd3) begin
          acc_q[prev_ch_q] <= '0;
          n_q[prev_ch_q]   <= '0;
          if (prev_ch_q) begin
            ch1_data_q <= sum[17:2];
            ch1_dv_q   <= 1'b1;
          end else begin
            ch0_data_q <= sum[17:2];
            ch0_dv_q   <= 1'b1;
          end
        end else begin
          acc_q[prev_ch_q] <= sum;
          n_q[prev_ch_q]   <= n_q[prev_ch_q] + 2'd1;
        end
      end
    end
  end
`else
  // Each accepted word goes straight to the previous frame's channel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ch0_data_q <= '0;
      ch1_data_q <= '0;
      ch0_dv_q   <= 1'b0;
      ch1_dv_q   <= 1'b0;
    end else begin
      ch0_dv_q <= 1'b0;
      ch1_dv_q <= 1'b0;
      if (accept) begin
        if (prev_ch_q) begin
          ch1_data_q <= ctrl.i_ctrl_data;
          ch1_dv_q   <= 1'b1;
        end else begin
          ch0_data_q <= ctrl.i_ctrl_data;
          ch0_dv_q   <= 1'b1;
        end
      end
    end
  end
`endif

  assign o_ch0_data = ch0_data_q;
  assign o_ch1_data = ch1_data_q;
  assign o_ch0_dv   = ch0_dv_q;
  assign o_ch1_dv   = ch1_dv_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_ltc1865_ch_scheduler.sv
// Scoreboard bench for ltc1865_ch_scheduler: a small ADC-controller model
// answers start pulses; expected channel results are queued when a word is
// returned and compared when the DUT pulses a dv.
module tb_ltc1865_ch_scheduler;
  localparam int unsigned GAP = 20;
  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [1:0]  mask;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_dv, ch1_dv, tmo;

  ltc1865_ch_scheduler_if bus();

  ltc1865_ch_scheduler #(
    .GAP_CLK    (GAP),
    .TIMEOUT_CLK(TMO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_run     (run),
    .i_ch_mask (mask),
    .ctrl      (bus),
    .o_ch0_data(ch0_data),
    .o_ch1_data(ch1_data),
    .o_ch0_dv  (ch0_dv),
    .o_ch1_dv  (ch1_dv),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ch;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_rx = -1;
  bit   mprev_valid;
  bit   mprev_ch;
`ifdef LTC1865_SCHED_AVG_EN
  int   macc [2];
  int   mn   [2];
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_idle();
    mprev_valid = 1'b0;
`ifdef LTC1865_SCHED_AVG_EN
    for (int i = 0; i < 2; i++) begin
      macc[i] = 0;
      mn[i]   = 0;
    end
`endif
  endfunction

  function automatic void model_rx(input bit ch, input logic [15:0] d);
    exp_t e;
    if (mprev_valid) begin
      e.ch = mprev_ch;
`ifdef LTC1865_SCHED_AVG_EN
      macc[mprev_ch] += int'(d);
      mn[mprev_ch]++;
      if (mn[mprev_ch] == 4) begin
        e.data = 16'(macc[mprev_ch] / 4);
        sbq.push_back(e);
        macc[mprev_ch] = 0;
        mn[mprev_ch]   = 0;
      end
`else
      e.data = d;
      sbq.push_back(e);
`endif
    end
    mprev_ch    = ch;
    mprev_valid = 1'b1;
  endfunction

  task automatic pop_cmp(input bit ch, input logic [15:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("dv_unexpected", 32'(ch), 32'hFFFF_FFFF);
    end else begin
      e = sbq.pop_front();
      chk("dv_ch", 32'(ch), 32'(e.ch));
      chk("dv_data", 32'(d), 32'(e.data));
    end
  endtask

  // Result monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (ch0_dv) pop_cmp(1'b0, ch0_data);
      if (ch1_dv) pop_cmp(1'b1, ch1_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ch, output bit ok);
    ok = 1'b0;
    ch = 1'b0;
    for (int i = 0; i < int'(GAP + TMO + 50) && !ok; i++) begin
      @(negedge clk);
      if (bus.o_ctrl_txe_n == 1'b0) begin
        ok = 1'b1;
        ch = bus.o_ctrl_ch;
      end
    end
    if (!ok) chk("start_seen", 32'd0, 32'd1);
  endtask

  task automatic do_frame(input bit exp_ch, input logic [15:0] d, input bit last);
    bit ch, ok;
    wait_start(ch, ok);
    if (ok) begin
      chk("start_ch", 32'(ch), 32'(exp_ch));
      chk("start_en", 32'(bus.o_ctrl_en), 32'd1);
      if (last_rx >= 0) chk("gap_ok", 32'((cyc - last_rx) >= int'(GAP)), 32'd1);
      step();
      if (last) run = 1'b0;
      chk("wait_ch", 32'(bus.o_ctrl_ch), 32'(exp_ch));
      chk("wait_txe", 32'(bus.o_ctrl_txe_n), 32'd1);
      step();
      step();
      bus.i_ctrl_rx_dv = 1'b1;
      bus.i_ctrl_data  = d;
      last_rx = cyc;
      model_rx(exp_ch, d);
      step();
      bus.i_ctrl_rx_dv = 1'b0;
      bus.i_ctrl_data  = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit found = 1'b0;
    for (int i = 0; i < int'(GAP + 20) && !found; i++) begin
      @(negedge clk);
      if (bus.o_ctrl_en == 1'b0) found = 1'b1;
    end
    chk("idle_reached", 32'(found), 32'd1);
    model_idle();
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},   32'(bus.o_ctrl_en),    32'd0);
    chk({tag, "_txe"},  32'(bus.o_ctrl_txe_n), 32'd1);
    chk({tag, "_ch"},   32'(bus.o_ctrl_ch),    32'd0);
    chk({tag, "_d0"},   32'(ch0_data),         32'd0);
    chk({tag, "_d1"},   32'(ch1_data),         32'd0);
    chk({tag, "_dv0"},  32'(ch0_dv),           32'd0);
    chk({tag, "_dv1"},  32'(ch1_dv),           32'd0);
    chk({tag, "_tmo"},  32'(tmo),              32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch, ok;
    int n;
    rst = 1'b1;
    run = 1'b0;
    mask = 2'b00;
    bus.i_ctrl_rx_dv = 1'b0;
    bus.i_ctrl_data  = '0;
    model_idle();
    repeat (3) step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // Alternating channels with priming frame; run drops during the last frame.
    mask = 2'b11;
    run  = 1'b1;
    do_frame(1'b0, 16'h1111, 1'b0);
    do_frame(1'b1, 16'h2222, 1'b0);
    do_frame(1'b0, 16'h3333, 1'b1);
    wait_idle();
`ifndef LTC1865_SCHED_AVG_EN
    chk("ch0_hold", 32'(ch0_data), 32'h2222);
    chk("ch1_hold", 32'(ch1_data), 32'h3333);
`endif

    // Only ch1 enabled, with a stray rx_dv injected during GAP.
    mask = 2'b10;
    run  = 1'b1;
    do_frame(1'b1, 16'hA001, 1'b0);
    repeat (3) step();
    bus.i_ctrl_rx_dv = 1'b1;
    bus.i_ctrl_data  = 16'hDEAD;
    step();
    bus.i_ctrl_rx_dv = 1'b0;
    do_frame(1'b1, 16'hA002, 1'b0);
    do_frame(1'b1, 16'hA003, 1'b1);
    wait_idle();

    // Only ch0: priming then 100, 200, 300, 400.
    mask = 2'b01;
    run  = 1'b1;
    do_frame(1'b0, 16'h0BAD, 1'b0);
    do_frame(1'b0, 16'd100, 1'b0);
    do_frame(1'b0, 16'd200, 1'b0);
    do_frame(1'b0, 16'd300, 1'b0);
    do_frame(1'b0, 16'd400, 1'b1);
    wait_idle();

    // Timeout: one good frame, then a start that never gets rx_dv.
    mask = 2'b11;
    run  = 1'b1;
    do_frame(1'b0, 16'h5555, 1'b0);
    wait_start(ch, ok);
    if (ok) begin
      chk("tmo_start_ch", 32'(ch), 32'd1);
      n = 0;
      while (!tmo && n < int'(TMO + 20)) begin
        @(negedge clk);
        n++;
      end
      chk("tmo_latency", 32'(n), 32'(TMO + 1));
      chk("tmo_idle_en", 32'(bus.o_ctrl_en), 32'd0);
      model_idle();
      step();
    end
    do_frame(1'b0, 16'h6666, 1'b0);
    do_frame(1'b1, 16'h7777, 1'b1);
    wait_idle();
    chk("tmo_sticky", 32'(tmo), 32'd1);

    // Run rising clears timeout; then reset in the middle of WAIT_DV.
    run = 1'b1;
    wait_start(ch, ok);
    chk("tmo_cleared", 32'(tmo), 32'd0);
    step();
    chk("mid_wait_en", 32'(bus.o_ctrl_en), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    model_idle();
    run = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("post_rst_en", 32'(bus.o_ctrl_en), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
